// File: rtl/axi4_axi4lite_bridge_if.sv
// AXI4 slave port and AXI4-Lite master port of the burst-splitting bridge.
// The slave modport is the bridge view; the master modport is the surrounding fabric.
interface axi4_axi4lite_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
);
   localparam int BB = DATA_W / 8;

   logic              inport_awvalid;
   logic              inport_awready;
   logic [ADDR_W-1:0] inport_awaddr;
   logic [ID_W-1:0]   inport_awid;
   logic [7:0]        inport_awlen;
   logic [1:0]        inport_awburst;
   logic              inport_wvalid;
   logic              inport_wready;
   logic [DATA_W-1:0] inport_wdata;
   logic [BB-1:0]     inport_wstrb;
   logic              inport_wlast;
   logic              inport_bvalid;
   logic              inport_bready;
   logic [1:0]        inport_bresp;
   logic [ID_W-1:0]   inport_bid;
   logic              inport_arvalid;
   logic              inport_arready;
   logic [ADDR_W-1:0] inport_araddr;
   logic [ID_W-1:0]   inport_arid;
   logic [7:0]        inport_arlen;
   logic [1:0]        inport_arburst;
   logic              inport_rvalid;
   logic              inport_rready;
   logic [DATA_W-1:0] inport_rdata;
   logic [1:0]        inport_rresp;
   logic [ID_W-1:0]   inport_rid;
   logic              inport_rlast;

   logic              outport_awvalid;
   logic              outport_awready;
   logic [ADDR_W-1:0] outport_awaddr;
   logic              outport_wvalid;
   logic              outport_wready;
   logic [DATA_W-1:0] outport_wdata;
   logic [BB-1:0]     outport_wstrb;
   logic              outport_bvalid;
   logic              outport_bready;
   logic [1:0]        outport_bresp;
   logic              outport_arvalid;
   logic              outport_arready;
   logic [ADDR_W-1:0] outport_araddr;
   logic              outport_rvalid;
   logic              outport_rready;
   logic [DATA_W-1:0] outport_rdata;
   logic [1:0]        outport_rresp;

   modport slave (
      input  inport_awvalid, inport_awaddr, inport_awid, inport_awlen, inport_awburst,
      output inport_awready,
      input  inport_wvalid, inport_wdata, inport_wstrb, inport_wlast,
      output inport_wready,
      output inport_bvalid, inport_bresp, inport_bid,
      input  inport_bready,
      input  inport_arvalid, inport_araddr, inport_arid, inport_arlen, inport_arburst,
      output inport_arready,
      output inport_rvalid, inport_rdata, inport_rresp, inport_rid, inport_rlast,
      input  inport_rready,
      output outport_awvalid, outport_awaddr,
      input  outport_awready,
      output outport_wvalid, outport_wdata, outport_wstrb,
      input  outport_wready,
      input  outport_bvalid, outport_bresp,
      output outport_bready,
      output outport_arvalid, outport_araddr,
      input  outport_arready,
      input  outport_rvalid, outport_rdata, outport_rresp,
      output outport_rready
   );

   modport master (
      output inport_awvalid, inport_awaddr, inport_awid, inport_awlen, inport_awburst,
      input  inport_awready,
      output inport_wvalid, inport_wdata, inport_wstrb, inport_wlast,
      input  inport_wready,
      input  inport_bvalid, inport_bresp, inport_bid,
      output inport_bready,
      output inport_arvalid, inport_araddr, inport_arid, inport_arlen, inport_arburst,
      input  inport_arready,
      input  inport_rvalid, inport_rdata, inport_rresp, inport_rid, inport_rlast,
      output inport_rready,
      input  outport_awvalid, outport_awaddr,
      output outport_awready,
      input  outport_wvalid, outport_wdata, outport_wstrb,
      output outport_wready,
      output outport_bvalid, outport_bresp,
      input  outport_bready,
      input  outport_arvalid, outport_araddr,
      output outport_arready,
      output outport_rvalid, outport_rdata, outport_rresp,
      input  outport_rready
   );
endinterface

// File: rtl/axi4_axi4lite_bridge.sv
// AXI4 to AXI4-Lite bridge: splits INCR/WRAP/FIXED bursts into single-beat Lite transfers.
// AXI4LITE_BRIDGE_BRESP_MERGE_EN selects worst-case merging of per-beat write responses.
//
// state   | meaning
// WR_IDLE | waiting for an inport AW burst
// WR_BUSY | issuing Lite AWs, passing W beats, collecting Lite Bs
// WR_RESP | presenting the merged B on the inport
// RD_IDLE | waiting for an inport AR burst
// RD_BUSY | issuing Lite ARs and passing R beats back
module axi4_axi4lite_bridge #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int ID_W   = 4
) (
   input logic                    clk_i,
   input logic                    rst_i,
   axi4_axi4lite_bridge_if.slave  bus
);
   localparam int BB = DATA_W / 8;

   typedef enum logic [1:0] {WR_IDLE, WR_BUSY, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_BUSY} rd_state_t;

   function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a,
                                                   input logic [7:0] len,
                                                   input logic [1:0] burst);
      logic [ADDR_W-1:0] inc;
      logic [ADDR_W-1:0] mask;
      logic              wrap_ok;
      inc     = a + ADDR_W'(BB);
      mask    = ADDR_W'(({1'b0, len} + 9'd1) * 9'(BB)) - ADDR_W'(1);
      wrap_ok = (burst == 2'd2) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      if (burst == 2'd0)
         return a;
      else if (wrap_ok)
         return (a & ~mask) | (inc & mask);
      else
         return inc;
   endfunction

   wr_state_t         wr_state;
   logic              awready_q, awvalid_q, bvalid_q;
   logic [ADDR_W-1:0] awaddr_q;
   logic [8:0]        aw_left, w_left, b_left;
   logic [7:0]        wr_len;
   logic [1:0]        wr_burst;
   logic [ID_W-1:0]   wr_id;
   logic [1:0]        resp_acc, b_merged;
   logic              wr_busy, w_ok, w_fire;

   rd_state_t         rd_state;
   logic              arready_q, arvalid_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [8:0]        ar_left, r_left;
   logic [7:0]        rd_len;
   logic [1:0]        rd_burst;
   logic [ID_W-1:0]   rd_id;
   logic              rd_busy, r_fire;

   logic              unused_wlast;
   assign unused_wlast = bus.inport_wlast;

   assign wr_busy = (wr_state == WR_BUSY);
   assign w_ok    = wr_busy && (w_left != 9'd0);
   assign w_fire  = w_ok && bus.inport_wvalid && bus.outport_wready;

   always_comb begin
`ifdef AXI4LITE_BRIDGE_BRESP_MERGE_EN
      b_merged = (bus.outport_bresp == 2'b01) ? 2'b00 : bus.outport_bresp;
      if (resp_acc > b_merged)
         b_merged = resp_acc;
`else
      b_merged = bus.outport_bresp;
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_state  <= WR_IDLE;
         awready_q <= 1'b1;
         awvalid_q <= 1'b0;
         bvalid_q  <= 1'b0;
         awaddr_q  <= '0;
         aw_left   <= '0;
         w_left    <= '0;
         b_left    <= '0;
         wr_len    <= '0;
         wr_burst  <= '0;
         wr_id     <= '0;
         resp_acc  <= '0;
      end else begin
         case (wr_state)
            WR_IDLE: if (bus.inport_awvalid) begin
               awready_q <= 1'b0;
               awvalid_q <= 1'b1;
               awaddr_q  <= bus.inport_awaddr;
               wr_len    <= bus.inport_awlen;
               wr_burst  <= bus.inport_awburst;
               wr_id     <= bus.inport_awid;
               aw_left   <= {1'b0, bus.inport_awlen} + 9'd1;
               w_left    <= {1'b0, bus.inport_awlen} + 9'd1;
               b_left    <= {1'b0, bus.inport_awlen} + 9'd1;
               resp_acc  <= 2'b00;
               wr_state  <= WR_BUSY;
            end
            WR_BUSY: begin
               if (awvalid_q && bus.outport_awready) begin
                  awaddr_q  <= next_addr(awaddr_q, wr_len, wr_burst);
                  aw_left   <= aw_left - 9'd1;
                  awvalid_q <= (aw_left != 9'd1);
               end
               if (w_fire)
                  w_left <= w_left - 9'd1;
               if (bus.outport_bvalid) begin
                  b_left   <= b_left - 9'd1;
                  resp_acc <= b_merged;
                  if (b_left == 9'd1) begin
                     bvalid_q <= 1'b1;
                     wr_state <= WR_RESP;
                  end
               end
            end
            WR_RESP: if (bus.inport_bready) begin
               bvalid_q  <= 1'b0;
               awready_q <= 1'b1;
               wr_state  <= WR_IDLE;
            end
            default: wr_state <= WR_IDLE;
         endcase
      end
   end

   assign bus.inport_awready  = awready_q;
   assign bus.outport_awvalid = awvalid_q;
   assign bus.outport_awaddr  = awaddr_q;
   assign bus.outport_wvalid  = w_ok && bus.inport_wvalid;
   assign bus.inport_wready   = w_ok && bus.outport_wready;
   assign bus.outport_wdata   = bus.inport_wdata;
   assign bus.outport_wstrb   = bus.inport_wstrb;
   assign bus.outport_bready  = wr_busy;
   assign bus.inport_bvalid   = bvalid_q;
   assign bus.inport_bresp    = resp_acc;
   assign bus.inport_bid      = wr_id;

   assign rd_busy = (rd_state == RD_BUSY);
   assign r_fire  = rd_busy && bus.outport_rvalid && bus.inport_rready;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_state  <= RD_IDLE;
         arready_q <= 1'b1;
         arvalid_q <= 1'b0;
         araddr_q  <= '0;
         ar_left   <= '0;
         r_left    <= '0;
         rd_len    <= '0;
         rd_burst  <= '0;
         rd_id     <= '0;
      end else begin
         case (rd_state)
            RD_IDLE: if (bus.inport_arvalid) begin
               arready_q <= 1'b0;
               arvalid_q <= 1'b1;
               araddr_q  <= bus.inport_araddr;
               rd_len    <= bus.inport_arlen;
               rd_burst  <= bus.inport_arburst;
               rd_id     <= bus.inport_arid;
               ar_left   <= {1'b0, bus.inport_arlen} + 9'd1;
               r_left    <= {1'b0, bus.inport_arlen} + 9'd1;
               rd_state  <= RD_BUSY;
            end
            RD_BUSY: begin
               if (arvalid_q && bus.outport_arready) begin
                  araddr_q  <= next_addr(araddr_q, rd_len, rd_burst);
                  ar_left   <= ar_left - 9'd1;
                  arvalid_q <= (ar_left != 9'd1);
               end
               if (r_fire) begin
                  r_left <= r_left - 9'd1;
                  if (r_left == 9'd1) begin
                     arready_q <= 1'b1;
                     rd_state  <= RD_IDLE;
                  end
               end
            end
            default: rd_state <= RD_IDLE;
         endcase
      end
   end

   assign bus.inport_arready  = arready_q;
   assign bus.outport_arvalid = arvalid_q;
   assign bus.outport_araddr  = araddr_q;
   assign bus.inport_rvalid   = rd_busy && bus.outport_rvalid;
   assign bus.outport_rready  = rd_busy && bus.inport_rready;
   assign bus.inport_rdata    = bus.outport_rdata;
   assign bus.inport_rresp    = bus.outport_rresp;
   assign bus.inport_rid      = rd_id;
   assign bus.inport_rlast    = (r_left == 9'd1);
endmodule

// File: tb/tb_axi4_axi4lite_bridge.sv
// Directed bench for axi4_axi4lite_bridge: a 32-bit instance for writes and reads,
// a 64-bit instance for the long FIXED read. Lite slaves are small behavioural models.
module tb_axi4_axi4lite_bridge;
   logic clk_i = 1'b0;
   logic rst_i = 1'b1;
   always #5 clk_i = ~clk_i;

   axi4_axi4lite_bridge_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();
   axi4_axi4lite_bridge_if #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) bus64 ();

   axi4_axi4lite_bridge #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) u_dut (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus));
   axi4_axi4lite_bridge #(.ADDR_W(32), .DATA_W(64), .ID_W(4)) u_dut64 (
      .clk_i(clk_i), .rst_i(rst_i), .bus(bus64));

   int n_chk = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Lite write slave: AW stalls aw_stall cycles per beat, W always ready, B per beat.
   int          aw_stall = 0, stall_ctr = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0;
   logic [31:0] aw_log[$];
   logic [31:0] w_log[$];
   logic [1:0]  b_tbl[16];

   initial forever begin
      @(negedge clk_i);
      bus.outport_awready = (stall_ctr == 0);
      bus.outport_wready  = 1'b1;
      bus.outport_bvalid  = (b_cnt < aw_cnt) && (b_cnt < w_cnt);
      bus.outport_bresp   = b_tbl[b_cnt % 16];
      #1;
      if (bus.outport_awvalid && bus.outport_awready) begin
         aw_log.push_back(bus.outport_awaddr);
         aw_cnt++;
         stall_ctr = aw_stall;
      end else if (bus.outport_awvalid && stall_ctr > 0)
         stall_ctr--;
      if (bus.outport_wvalid && bus.outport_wready) begin
         w_log.push_back(bus.outport_wdata);
         w_cnt++;
      end
      if (bus.outport_bvalid && bus.outport_bready)
         b_cnt++;
   end

   // Lite read slave: data = addr ^ 32'h5A5A_0000, one cycle after the AR.
   logic [31:0] ar_log[$];
   logic [31:0] ar_pend[$];
   int          r_cnt = 0;

   initial forever begin
      @(negedge clk_i);
      bus.outport_arready = 1'b1;
      bus.outport_rvalid  = (ar_pend.size() > 0);
      bus.outport_rdata   = (ar_pend.size() > 0) ? (ar_pend[0] ^ 32'h5A5A_0000) : 32'h0;
      bus.outport_rresp   = 2'b00;
      #1;
      if (rst_i)
         ar_pend.delete();
      else begin
         if (bus.outport_rvalid && bus.outport_rready) begin
            void'(ar_pend.pop_front());
            r_cnt++;
         end
         if (bus.outport_arvalid && bus.outport_arready) begin
            ar_pend.push_back(bus.outport_araddr);
            ar_log.push_back(bus.outport_araddr);
         end
      end
   end

   // 64-bit read slave: data = {32'h6464_0000, beat index}.
   int          ar64_cnt = 0, ar64_bad = 0, r64_pend = 0, r64_sent = 0;
   logic [31:0] ar64_exp = 32'h0;

   initial forever begin
      @(negedge clk_i);
      bus64.outport_arready = 1'b1;
      bus64.outport_rvalid  = (r64_pend > 0);
      bus64.outport_rdata   = {32'h6464_0000, 32'(r64_sent)};
      bus64.outport_rresp   = 2'b00;
      #1;
      if (bus64.outport_rvalid && bus64.outport_rready) begin
         r64_pend--;
         r64_sent++;
      end
      if (bus64.outport_arvalid && bus64.outport_arready) begin
         ar64_cnt++;
         r64_pend++;
         if (bus64.outport_araddr != ar64_exp)
            ar64_bad++;
      end
   end

   logic [31:0] rd_data[$];
   logic        rd_last[$];
   logic [3:0]  rd_id[$];

   task automatic wr_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst, output logic [1:0] resp, output logic [3:0] bid);
      int n, t;
      resp = 2'bxx;
      bid  = 4'bxxxx;
      @(negedge clk_i);
      bus.inport_awaddr = a; bus.inport_awid = id; bus.inport_awlen = len;
      bus.inport_awburst = burst; bus.inport_awvalid = 1'b1;
      #1; t = 0;
      while (!bus.inport_awready && t < 100) begin @(negedge clk_i); #1; t++; end
      chk("aw_accept", 64'(t < 100), 1);
      @(negedge clk_i);
      bus.inport_awvalid = 1'b0;
      n = 0;
      bus.inport_wvalid = 1'b1; bus.inport_wdata = 32'hA000_0000;
      bus.inport_wstrb = 4'hF; bus.inport_wlast = (len == 8'd0);
      #1;
      chk("aw_issue_lat", bus.outport_awvalid, 1);
      chk("aw_busy_hold", bus.inport_awready, 0);
      t = 0;
      while (n <= int'(len) && t < 2000) begin
         if (bus.inport_wready) n++;
         @(negedge clk_i);
         if (n <= int'(len)) begin
            bus.inport_wdata = 32'hA000_0000 + 32'(n);
            bus.inport_wlast = (n == int'(len));
         end else
            bus.inport_wvalid = 1'b0;
         #1; t++;
      end
      chk("w_beats", n, int'(len) + 1);
      t = 0;
      while (!bus.inport_bvalid && t < 2000) begin @(negedge clk_i); #1; t++; end
      chk("b_wait", 64'(t < 2000), 1);
      chk("aw_held_until_b", bus.inport_awready, 0);
      resp = bus.inport_bresp;
      bid  = bus.inport_bid;
      bus.inport_bready = 1'b1;
      @(negedge clk_i);
      bus.inport_bready = 1'b0;
      #1;
      chk("b_done", bus.inport_bvalid, 0);
      chk("aw_ready_after_b", bus.inport_awready, 1);
   endtask

   task automatic rd_burst(input logic [31:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [1:0] burst);
      int n, t;
      @(negedge clk_i);
      bus.inport_araddr = a; bus.inport_arid = id; bus.inport_arlen = len;
      bus.inport_arburst = burst; bus.inport_arvalid = 1'b1;
      #1; t = 0;
      while (!bus.inport_arready && t < 100) begin @(negedge clk_i); #1; t++; end
      chk("ar_accept", 64'(t < 100), 1);
      @(negedge clk_i);
      bus.inport_arvalid = 1'b0;
      bus.inport_rready  = 1'b1;
      #1;
      chk("ar_issue_lat", bus.outport_arvalid, 1);
      chk("ar_busy_hold", bus.inport_arready, 0);
      n = 0; t = 0;
      while (n < int'(len) + 1 && t < 2000) begin
         if (bus.inport_rvalid) begin
            rd_data.push_back(bus.inport_rdata);
            rd_last.push_back(bus.inport_rlast);
            rd_id.push_back(bus.inport_rid);
            n++;
         end
         if (n < int'(len) + 1) begin @(negedge clk_i); #1; t++; end
      end
      chk("r_beats", n, int'(len) + 1);
      @(negedge clk_i);
      bus.inport_rready = 1'b0;
      #1;
      chk("ar_ready_after_r", bus.inport_arready, 1);
   endtask

   task automatic clear_logs();
      aw_log.delete(); w_log.delete(); ar_log.delete();
      rd_data.delete(); rd_last.delete(); rd_id.delete();
      aw_cnt = 0; w_cnt = 0; b_cnt = 0; r_cnt = 0;
      for (int i = 0; i < 16; i++) b_tbl[i] = 2'b00;
   endtask

   initial begin
      logic [1:0] resp;
      logic [3:0] bid;
      int n, t, nlast, lastpos, ndbad, ridbad;

      bus.inport_awvalid = 0; bus.inport_awaddr = 0; bus.inport_awid = 0;
      bus.inport_awlen = 0; bus.inport_awburst = 0;
      bus.inport_wvalid = 0; bus.inport_wdata = 0; bus.inport_wstrb = 0; bus.inport_wlast = 0;
      bus.inport_bready = 0;
      bus.inport_arvalid = 0; bus.inport_araddr = 0; bus.inport_arid = 0;
      bus.inport_arlen = 0; bus.inport_arburst = 0; bus.inport_rready = 0;
      bus.outport_awready = 0; bus.outport_wready = 0; bus.outport_bvalid = 0;
      bus.outport_bresp = 0; bus.outport_arready = 0; bus.outport_rvalid = 0;
      bus.outport_rdata = 0; bus.outport_rresp = 0;
      bus64.inport_awvalid = 0; bus64.inport_awaddr = 0; bus64.inport_awid = 0;
      bus64.inport_awlen = 0; bus64.inport_awburst = 0;
      bus64.inport_wvalid = 0; bus64.inport_wdata = 0; bus64.inport_wstrb = 0; bus64.inport_wlast = 0;
      bus64.inport_bready = 0;
      bus64.inport_arvalid = 0; bus64.inport_araddr = 0; bus64.inport_arid = 0;
      bus64.inport_arlen = 0; bus64.inport_arburst = 0; bus64.inport_rready = 0;
      bus64.outport_awready = 0; bus64.outport_wready = 0; bus64.outport_bvalid = 0;
      bus64.outport_bresp = 0; bus64.outport_arready = 0; bus64.outport_rvalid = 0;
      bus64.outport_rdata = 0; bus64.outport_rresp = 0;
      clear_logs();

      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_awready", bus.inport_awready, 1);
      chk("rst_arready", bus.inport_arready, 1);
      chk("rst_bvalid", bus.inport_bvalid, 0);
      chk("rst_rvalid", bus.inport_rvalid, 0);
      chk("rst_o_awvalid", bus.outport_awvalid, 0);
      chk("rst_o_arvalid", bus.outport_arvalid, 0);
      chk("rst_o_wvalid", bus.outport_wvalid, 0);
      chk("rst_o_bready", bus.outport_bready, 0);
      chk("rst_o_rready", bus.outport_rready, 0);
      chk("rst_bresp", bus.inport_bresp, 0);
      chk("rst_rlast", bus.inport_rlast, 0);
      chk("rst_bid", bus.inport_bid, 0);
      chk("rst_rid", bus.inport_rid, 0);
      chk("rst_awaddr", bus.outport_awaddr, 0);
      chk("rst_araddr", bus.outport_araddr, 0);
      @(negedge clk_i);
      rst_i = 1'b0;

      // INCR write with Lite AWREADY stalled two cycles per beat
      clear_logs();
      aw_stall = 2; stall_ctr = 2;
      wr_burst(32'h100, 4'h5, 8'd3, 2'b01, resp, bid);
      chk("incr_aw_count", aw_log.size(), 4);
      for (int i = 0; i < 4 && i < aw_log.size(); i++)
         chk($sformatf("incr_aw_addr%0d", i), aw_log[i], 32'h100 + 32'(4 * i));
      chk("incr_w_count", w_log.size(), 4);
      for (int i = 0; i < 4 && i < w_log.size(); i++)
         chk($sformatf("incr_w_data%0d", i), w_log[i], 32'hA000_0000 + 32'(i));
      chk("incr_bresp", resp, 2'b00);
      chk("incr_bid", bid, 4'h5);

      // WRAP read, 4 beats wrapping inside a 16-byte window
      clear_logs();
      aw_stall = 0; stall_ctr = 0;
      rd_burst(32'h1C, 4'h9, 8'd3, 2'b10);
      chk("wrap_ar_count", ar_log.size(), 4);
      if (ar_log.size() == 4) begin
         chk("wrap_ar0", ar_log[0], 32'h1C);
         chk("wrap_ar1", ar_log[1], 32'h10);
         chk("wrap_ar2", ar_log[2], 32'h14);
         chk("wrap_ar3", ar_log[3], 32'h18);
      end
      if (rd_data.size() == 4) begin
         chk("wrap_rdata0", rd_data[0], 32'h5A5A_001C);
         chk("wrap_rdata1", rd_data[1], 32'h5A5A_0010);
         chk("wrap_rdata3", rd_data[3], 32'h5A5A_0018);
         chk("wrap_rlast", {rd_last[0], rd_last[1], rd_last[2], rd_last[3]}, 4'b0001);
         chk("wrap_rid", rd_id[2], 4'h9);
      end

      // Write with SLVERR on the second beat only
      clear_logs();
      b_tbl[1] = 2'b10;
      wr_burst(32'h200, 4'h3, 8'd3, 2'b01, resp, bid);
`ifdef AXI4LITE_BRIDGE_BRESP_MERGE_EN
      chk("merge_bresp", resp, 2'b10);
`else
      chk("merge_bresp", resp, 2'b00);
`endif
      chk("merge_bid", bid, 4'h3);

      // Single-beat FIXED write with DECERR
      clear_logs();
      b_tbl[0] = 2'b11;
      wr_burst(32'h300, 4'hA, 8'd0, 2'b00, resp, bid);
      chk("single_aw_count", aw_log.size(), 1);
      if (aw_log.size() == 1) chk("single_aw_addr", aw_log[0], 32'h300);
      chk("single_bresp", resp, 2'b11);

      // 64-bit FIXED read, 256 beats, random rready stalls
      ar64_exp = 32'h2000;
      @(negedge clk_i);
      bus64.inport_araddr = 32'h2000; bus64.inport_arid = 4'hC;
      bus64.inport_arlen = 8'd255; bus64.inport_arburst = 2'b00; bus64.inport_arvalid = 1'b1;
      #1;
      chk("fix_ar_accept", bus64.inport_arready, 1);
      @(negedge clk_i);
      bus64.inport_arvalid = 1'b0;
      n = 0; t = 0; nlast = 0; lastpos = -1; ndbad = 0; ridbad = 0;
      while (n < 256 && t < 4000) begin
         bus64.inport_rready = ($urandom_range(0, 3) != 0);
         #1;
         if (bus64.inport_rvalid && bus64.inport_rready) begin
            if (bus64.inport_rdata != {32'h6464_0000, 32'(n)}) ndbad++;
            if (bus64.inport_rlast) begin nlast++; lastpos = n; end
            if (bus64.inport_rid != 4'hC) ridbad++;
            n++;
         end
         @(negedge clk_i); t++;
      end
      bus64.inport_rready = 1'b0;
      #1;
      chk("fix_r_beats", n, 256);
      chk("fix_ar_count", ar64_cnt, 256);
      chk("fix_ar_addr_bad", ar64_bad, 0);
      chk("fix_rlast_count", nlast, 1);
      chk("fix_rlast_pos", lastpos, 255);
      chk("fix_rdata_bad", ndbad, 0);
      chk("fix_rid_bad", ridbad, 0);
      chk("fix_arready_after", bus64.inport_arready, 1);

      // Concurrent AW len=1 and AR len=0 in the same cycle
      clear_logs();
      fork
         wr_burst(32'h400, 4'h6, 8'd1, 2'b01, resp, bid);
         rd_burst(32'h500, 4'h7, 8'd0, 2'b01);
      join
      chk("conc_aw_count", aw_log.size(), 2);
      if (aw_log.size() == 2) chk("conc_aw1", aw_log[1], 32'h404);
      chk("conc_bresp", resp, 2'b00);
      chk("conc_bid", bid, 4'h6);
      chk("conc_r_count", rd_data.size(), 1);
      if (rd_data.size() == 1) begin
         chk("conc_rdata", rd_data[0], 32'h5A5A_0500);
         chk("conc_rlast", rd_last[0], 1);
         chk("conc_rid", rd_id[0], 4'h7);
      end

      // Reset during an 8-beat read after two beats
      clear_logs();
      @(negedge clk_i);
      bus.inport_araddr = 32'h600; bus.inport_arid = 4'h2; bus.inport_arlen = 8'd7;
      bus.inport_arburst = 2'b01; bus.inport_arvalid = 1'b1; bus.inport_rready = 1'b1;
      @(negedge clk_i);
      bus.inport_arvalid = 1'b0;
      t = 0;
      while (r_cnt < 2 && t < 50) begin @(negedge clk_i); t++; end
      chk("rstmid_two_beats", r_cnt, 2);
      rst_i = 1'b1;
      bus.inport_rready = 1'b0;
      #1;
      chk("rstmid_o_arvalid", bus.outport_arvalid, 0);
      chk("rstmid_o_awvalid", bus.outport_awvalid, 0);
      chk("rstmid_o_rready", bus.outport_rready, 0);
      chk("rstmid_rvalid", bus.inport_rvalid, 0);
      chk("rstmid_arready", bus.inport_arready, 1);
      @(negedge clk_i);
      rst_i = 1'b0;
      #1;
      chk("rstpost_o_arvalid", bus.outport_arvalid, 0);
      chk("rstpost_arready", bus.inport_arready, 1);
      clear_logs();
      rd_burst(32'h700, 4'h4, 8'd1, 2'b01);
      chk("rstnew_ar_count", ar_log.size(), 2);
      if (rd_data.size() == 2) begin
         chk("rstnew_rdata1", rd_data[1], 32'h5A5A_0704);
         chk("rstnew_rlast", {rd_last[0], rd_last[1]}, 2'b01);
         chk("rstnew_rid", rd_id[0], 4'h4);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got=running exp=finished");
      $fatal(1, "timeout");
   end
endmodule
